// File: rtl/multicycle_control.sv
// Sequencing FSM for the multicycle RV32I core. Each instruction is stepped
// through FETCH/DECODE/EXECUTE/MEM/WRITEBACK. The block drives the shared ALU
// selects, the register file, PC and instruction/data memory requests, waits on
// the memory ready handshakes, and halts with a sticky bus_error when a memory
// request waits MEM_TIMEOUT cycles without a ready (MEM_TIMEOUT=0 disables it).
//
// Ports:
//   clock, reset                 core clock, async active-high reset
//   inst_opcode, inst_bit_30     IR fields (stable from DECODE onward)
//   inst_mem_ready               instruction read data valid this cycle
//   data_mem_ready               data load/store completes this cycle
//   inst_mem_read_enable         instruction fetch request
//   ir_write_enable              load IR from the instruction bus
//   pc_write_enable              update PC
//   regfile_write_enable         write rd
//   alu_operand_a_select/_b_     ALU operand selects (CTL_ALU_A_*/CTL_ALU_B_*)
//   alu_op_type                  ALU operation (CTL_ALU_*)
//   jal_enable, jalr_enable      jump PC sources at writeback
//   branch_enable                conditional PC update in EXECUTE
//   data_mem_read/write_enable   load/store request
//   reg_writeback_select         rd source (CTL_WRITEBACK_*)
//   bus_error                    sticky memory timeout flag
//   state                        current FSM state (debug)
module multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] inst_opcode,
  input  logic       inst_bit_30,
  input  logic       inst_mem_ready,
  input  logic       data_mem_ready,
  output logic       inst_mem_read_enable,
  output logic       ir_write_enable,
  output logic       pc_write_enable,
  output logic       regfile_write_enable,
  output logic       alu_operand_a_select,
  output logic       alu_operand_b_select,
  output logic [2:0] alu_op_type,
  output logic       jal_enable,
  output logic       jalr_enable,
  output logic       branch_enable,
  output logic       data_mem_read_enable,
  output logic       data_mem_write_enable,
  output logic [2:0] reg_writeback_select,
  output logic       bus_error,
  output logic [2:0] state
);

  localparam logic [6:0] OPC_LOAD     = 7'h03;
  localparam logic [6:0] OPC_MISC_MEM = 7'h0F;
  localparam logic [6:0] OPC_OP_IMM   = 7'h13;
  localparam logic [6:0] OPC_AUIPC    = 7'h17;
  localparam logic [6:0] OPC_STORE    = 7'h23;
  localparam logic [6:0] OPC_OP       = 7'h33;
  localparam logic [6:0] OPC_LUI      = 7'h37;
  localparam logic [6:0] OPC_BRANCH   = 7'h63;
  localparam logic [6:0] OPC_JALR     = 7'h67;
  localparam logic [6:0] OPC_JAL      = 7'h6F;

  localparam logic       CTL_ALU_A_RS1 = 1'b0;
  localparam logic       CTL_ALU_A_PC  = 1'b1;
  localparam logic       CTL_ALU_B_RS2 = 1'b0;
  localparam logic       CTL_ALU_B_IMM = 1'b1;

  localparam logic [2:0] CTL_ALU_ZERO      = 3'd0;
  localparam logic [2:0] CTL_ALU_ADD       = 3'd1;
  localparam logic [2:0] CTL_ALU_DEFAULT   = 3'd2;
  localparam logic [2:0] CTL_ALU_SECONDARY = 3'd3;
  localparam logic [2:0] CTL_ALU_BRANCH    = 3'd4;

  localparam logic [2:0] CTL_WRITEBACK_ALU  = 3'd0;
  localparam logic [2:0] CTL_WRITEBACK_DATA = 3'd1;
  localparam logic [2:0] CTL_WRITEBACK_PC4  = 3'd2;
  localparam logic [2:0] CTL_WRITEBACK_IMM  = 3'd3;

  localparam int unsigned CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic            bus_error_q, bus_error_d;

  logic            ex_a_sel, ex_b_sel, known_op;
  logic [2:0]      ex_alu_op;
  logic            timeout_hit;

  // Counter holds the number of ready=0 cycles already waited; the limit is
  // hit on the cycle that would make it MEM_TIMEOUT.
  assign timeout_hit = (MEM_TIMEOUT != 0) && (count_q == CW'(MEM_TIMEOUT - 1));

  // EXECUTE ALU setup; reused in MEM and WRITEBACK so the ALU result stays valid.
  always_comb begin
    ex_a_sel  = CTL_ALU_A_RS1;
    ex_b_sel  = CTL_ALU_B_RS2;
    ex_alu_op = CTL_ALU_ZERO;
    known_op  = 1'b1;
    case (inst_opcode)
      OPC_LOAD, OPC_STORE: begin
        ex_b_sel  = CTL_ALU_B_IMM;
        ex_alu_op = CTL_ALU_ADD;
      end
      OPC_OP_IMM: begin
        ex_b_sel  = CTL_ALU_B_IMM;
        ex_alu_op = CTL_ALU_DEFAULT;
      end
      OPC_OP:       ex_alu_op = inst_bit_30 ? CTL_ALU_SECONDARY : CTL_ALU_DEFAULT;
      OPC_AUIPC, OPC_JAL: begin
        ex_a_sel  = CTL_ALU_A_PC;
        ex_b_sel  = CTL_ALU_B_IMM;
        ex_alu_op = CTL_ALU_ADD;
      end
      OPC_JALR: begin
        ex_b_sel  = CTL_ALU_B_IMM;
        ex_alu_op = CTL_ALU_ADD;
      end
      OPC_BRANCH:   ex_alu_op = CTL_ALU_BRANCH;
      OPC_LUI, OPC_MISC_MEM: ex_alu_op = CTL_ALU_ZERO;
      default:      known_op = 1'b0;
    endcase
  end

  always_comb begin
    state_d               = state_q;
    count_d               = '0;
    bus_error_d           = bus_error_q;
    inst_mem_read_enable  = 1'b0;
    ir_write_enable       = 1'b0;
    pc_write_enable       = 1'b0;
    regfile_write_enable  = 1'b0;
    alu_operand_a_select  = CTL_ALU_A_RS1;
    alu_operand_b_select  = CTL_ALU_B_RS2;
    alu_op_type           = CTL_ALU_ZERO;
    jal_enable            = 1'b0;
    jalr_enable           = 1'b0;
    branch_enable         = 1'b0;
    data_mem_read_enable  = 1'b0;
    data_mem_write_enable = 1'b0;
    reg_writeback_select  = CTL_WRITEBACK_ALU;

    case (state_q)
      S_FETCH: begin
        inst_mem_read_enable = 1'b1;
        if (inst_mem_ready) begin
          ir_write_enable = 1'b1;
          state_d         = S_DECODE;
        end else if (timeout_hit) begin
          state_d     = S_HALT;
          bus_error_d = 1'b1;
        end else if (MEM_TIMEOUT != 0) begin
          count_d = count_q + CW'(1);
        end
      end
      S_DECODE: begin
        if (known_op) begin
          state_d = S_EXECUTE;
        end else begin
          pc_write_enable = 1'b1;
          state_d         = S_FETCH;
        end
      end
      S_EXECUTE: begin
        alu_operand_a_select = ex_a_sel;
        alu_operand_b_select = ex_b_sel;
        alu_op_type          = ex_alu_op;
        case (inst_opcode)
          OPC_LOAD, OPC_STORE: state_d = S_MEM;
          OPC_BRANCH: begin
            branch_enable   = 1'b1;
            pc_write_enable = 1'b1;
            state_d         = S_FETCH;
          end
          OPC_MISC_MEM: begin
            pc_write_enable = 1'b1;
            state_d         = S_FETCH;
          end
          default: state_d = S_WRITEBACK;
        endcase
      end
      S_MEM: begin
        alu_operand_a_select = ex_a_sel;
        alu_operand_b_select = ex_b_sel;
        alu_op_type          = ex_alu_op;
        if (inst_opcode == OPC_LOAD) data_mem_read_enable  = 1'b1;
        else                         data_mem_write_enable = 1'b1;
        if (data_mem_ready) begin
          if (inst_opcode == OPC_LOAD) begin
            state_d = S_WRITEBACK;
          end else begin
            pc_write_enable = 1'b1;
            state_d         = S_FETCH;
          end
        end else if (timeout_hit) begin
          state_d     = S_HALT;
          bus_error_d = 1'b1;
        end else if (MEM_TIMEOUT != 0) begin
          count_d = count_q + CW'(1);
        end
      end
      S_WRITEBACK: begin
        alu_operand_a_select = ex_a_sel;
        alu_operand_b_select = ex_b_sel;
        alu_op_type          = ex_alu_op;
        regfile_write_enable = 1'b1;
        pc_write_enable      = 1'b1;
        state_d              = S_FETCH;
        case (inst_opcode)
          OPC_LOAD: reg_writeback_select = CTL_WRITEBACK_DATA;
          OPC_JAL: begin
            reg_writeback_select = CTL_WRITEBACK_PC4;
            jal_enable           = 1'b1;
          end
          OPC_JALR: begin
            reg_writeback_select = CTL_WRITEBACK_PC4;
            jalr_enable          = 1'b1;
          end
          OPC_LUI:  reg_writeback_select = CTL_WRITEBACK_IMM;
          default:  reg_writeback_select = CTL_WRITEBACK_ALU;
        endcase
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    // Reset forces FETCH asynchronously; mask its fetch request (and any
    // in-flight write) for as long as reset is held.
    if (reset) begin
      inst_mem_read_enable  = 1'b0;
      ir_write_enable       = 1'b0;
      pc_write_enable       = 1'b0;
      regfile_write_enable  = 1'b0;
      jal_enable            = 1'b0;
      jalr_enable           = 1'b0;
      branch_enable         = 1'b0;
      data_mem_read_enable  = 1'b0;
      data_mem_write_enable = 1'b0;
      alu_op_type           = CTL_ALU_ZERO;
      reg_writeback_select  = CTL_WRITEBACK_ALU;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_FETCH;
      count_q     <= '0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      bus_error_q <= bus_error_d;
    end
  end

  assign bus_error = bus_error_q;
  assign state     = state_q;

endmodule
